// File: rtl/jk_updown_counter.sv
// jk_updown_counter
// Parametrised up/down modulo counter built from per-bit JK toggle cells.
// Features: programmable terminal value MAX, synchronous parallel load with
// clamping to MAX, enable/direction control and a combinational cascade
// carry (tc) for chaining stages.
// Build option: define JK_UPDOWN_SAT_EN to saturate at the range ends
// instead of wrapping. tc still flags the boundary in that build.
module jk_updown_counter #(
   parameter int WIDTH = 4,
   parameter int MAX   = 2**WIDTH - 1
) (
   input  logic             c,
   input  logic             reset_n,
   input  logic             e,
   input  logic             f,
   input  logic             ld,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q1,
   output logic             tc
);

`ifdef JK_UPDOWN_SAT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic [WIDTH-1:0] toggle;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] wrap_val;
   logic             at_max;
   logic             at_zero;
   logic             over_range;
   logic             run_up;
   logic             run_dn;

   // A full-range counter can never be out of range, and no load value can
   // exceed MAX, so those comparisons are only built when MAX < 2**WIDTH-1.
   if (MAX == 2**WIDTH - 1) begin : g_full_range
      assign over_range = 1'b0;
      assign load_val   = d;
   end else begin : g_part_range
      assign over_range = (count_q > MAX_W);
      assign load_val   = (d > MAX_W) ? MAX_W : d;
   end

   // Boundary detection on the current count.
   always_comb begin
      at_max  = (count_q == MAX_W);
      at_zero = (count_q == '0);
   end

   // Per-bit toggle request: binary ripple toggles, replaced by the
   // load / wrap / saturate target whenever the plain ripple would be wrong.
   always_comb begin
      // NOTE: every variable gets a default before any branch so no path
      // leaves it unassigned; otherwise synthesis infers a latch.
      toggle   = '0;
      wrap_val = '0;
      run_up   = 1'b1;
      run_dn   = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         toggle[i] = f ? run_up : run_dn;
         run_up    = run_up & count_q[i];
         run_dn    = run_dn & ~count_q[i];
      end
      if (ld) begin
         toggle = load_val ^ count_q;
      end else if (!e) begin
         toggle = '0;
      end else if (f && (at_max || over_range)) begin
         wrap_val = (SAT_EN && at_max) ? count_q : '0;
         toggle   = wrap_val ^ count_q;
      end else if (!f && (at_zero || over_range)) begin
         wrap_val = (SAT_EN && at_zero) ? count_q : MAX_W;
         toggle   = wrap_val ^ count_q;
      end
   end

   // JK cell per bit with J = K = toggle: 00 hold, 11 toggle.
   always_comb begin
      count_d = count_q;
      for (int i = 0; i < WIDTH; i++) begin
         unique case ({toggle[i], toggle[i]})
            2'b00:   count_d[i] = count_q[i];
            2'b01:   count_d[i] = 1'b0;
            2'b10:   count_d[i] = 1'b1;
            default: count_d[i] = ~count_q[i];
         endcase
      end
   end

   // Count register with asynchronous clear.
   always_ff @(posedge c or negedge reset_n) begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples the pre-edge values, independent of statement order.
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign q  = count_q;
   assign q1 = ~count_q;
   assign tc = e & ~ld & ((f & at_max) | (~f & at_zero));

endmodule
